// File: rtl/utmi_rx_pkg.sv
// rtl/utmi_rx_pkg.sv - shared types and constants for the UTMI receive framer
package utmi_rx_pkg;

    localparam int LEN_W = 11;
    localparam int OVF_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRST   = 3'd1,
        RUN     = 3'd2,
        PEND    = 3'd3,
        DISCARD = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic       err;
        logic       eop;
        logic       sop;
        logic [7:0] data;
    } rx_entry_t;

    // A USB PID carries its own check nibble: the high nibble is the complement of the low nibble.
    function automatic logic pid_valid(input logic [7:0] pid);
        return pid[3:0] == ~pid[7:4];
    endfunction

endpackage

// File: rtl/utmi_rx_fifo.sv
// rtl/utmi_rx_fifo.sv - synchronous entry FIFO with occupancy count, no fall-through
module utmi_rx_fifo
    import utmi_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en_i,
    input  rx_entry_t              wr_entry_i,
    input  logic                   rd_en_i,
    output logic                   rd_valid_o,
    output rx_entry_t              rd_entry_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en_i & ~full;
    assign pop   = rd_en_i & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty since the head is masked.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry_i;
    end

    assign rd_valid_o = ~empty;
    assign rd_entry_o = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/utmi_rx_framer.sv
// rtl/utmi_rx_framer.sv - UTMI receive framer: packet delimiting, overflow drop, entry FIFO (option: UTMI_RX_PID_CHECK_EN)
module utmi_rx_framer
    import utmi_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             utmi_rxactive,
    input  logic             utmi_rxvalid,
    input  logic             utmi_rxerror,
    input  logic [7:0]       utmi_rxdata,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_done,
    output logic [OVF_W-1:0] ovf_cnt
);

    localparam int              CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DATA_LIM = CW'(DEPTH - 2);
    localparam logic [CW-1:0]   EOP_LIM  = CW'(DEPTH - 1);

    rx_state_t          state_q;
    rx_entry_t          hold_q;
    logic               err_q;
    logic               boot_q;
    logic [LEN_W-1:0]   byte_cnt_q;
    logic [LEN_W-1:0]   pkt_len_q;
    logic               pkt_done_q;
    logic [OVF_W-1:0]   ovf_q;

    logic [CW-1:0]      fifo_count;
    logic               data_room;
    logic               eop_room;
    logic               byte_in;
    logic               pid_bad;
    logic               wr_en_d;
    logic               eop_wr_d;
    logic               drop_d;
    logic               ovf_inc_d;
    rx_entry_t          wr_entry_d;
    rx_entry_t          head;

    assign data_room = (fifo_count <= DATA_LIM);
    assign eop_room  = (fifo_count <= EOP_LIM);
    assign byte_in   = utmi_rxactive & utmi_rxvalid;

`ifdef UTMI_RX_PID_CHECK_EN
    assign pid_bad = ~pid_valid(utmi_rxdata);
`else
    assign pid_bad = 1'b0;
`endif

    // Decide whether the held byte is written, dropped, or closes the packet this cycle.
    always_comb begin
        wr_en_d    = 1'b0;
        eop_wr_d   = 1'b0;
        drop_d     = 1'b0;
        wr_entry_d = hold_q;
        case (state_q)
            RUN: begin
                if (!utmi_rxactive) begin
                    if (eop_room) begin
                        wr_en_d  = 1'b1;
                        eop_wr_d = 1'b1;
                    end
                end else if (utmi_rxvalid) begin
                    if (data_room) wr_en_d = 1'b1;
                    else           drop_d  = 1'b1;
                end
            end
            PEND: begin
                if (eop_room) begin
                    wr_en_d  = 1'b1;
                    eop_wr_d = 1'b1;
                end
            end
            default: ;
        endcase
        wr_entry_d.eop = eop_wr_d;
        wr_entry_d.err = eop_wr_d & err_q;
        ovf_inc_d      = drop_d | (byte_in & ((state_q == PEND) | (state_q == DISCARD)));
    end

    // Framer FSM with hold register, sticky error, byte counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            err_q      <= 1'b0;
            boot_q     <= 1'b1;
            byte_cnt_q <= '0;
            pkt_len_q  <= '0;
            pkt_done_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            boot_q     <= 1'b0;
            pkt_done_q <= 1'b0;
            if (ovf_inc_d && (ovf_q != '1)) ovf_q <= ovf_q + 1'b1;
            case (state_q)
                IDLE: begin
                    // Activity already in progress at reset release is a packet we joined mid-way.
                    if (utmi_rxactive) begin
                        if (boot_q) begin
                            state_q <= DISCARD;
                        end else begin
                            state_q    <= FIRST;
                            err_q      <= 1'b0;
                            byte_cnt_q <= '0;
                        end
                    end
                end
                FIRST: begin
                    if (!utmi_rxactive) begin
                        state_q <= IDLE;
                    end else begin
                        if (utmi_rxerror) err_q <= 1'b1;
                        if (utmi_rxvalid) begin
                            hold_q     <= '{err: 1'b0, eop: 1'b0, sop: 1'b1, data: utmi_rxdata};
                            byte_cnt_q <= LEN_W'(1);
                            if (pid_bad) err_q <= 1'b1;
                            state_q    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!utmi_rxactive) begin
                        if (eop_wr_d) begin
                            pkt_len_q  <= byte_cnt_q;
                            pkt_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= PEND;
                        end
                    end else begin
                        if (utmi_rxerror) err_q <= 1'b1;
                        if (utmi_rxvalid) begin
                            hold_q <= '{err: 1'b0, eop: 1'b0, sop: 1'b0, data: utmi_rxdata};
                            if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
                            if (drop_d) err_q <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (eop_wr_d) begin
                        pkt_len_q  <= byte_cnt_q;
                        pkt_done_q <= 1'b1;
                        state_q    <= utmi_rxactive ? DISCARD : IDLE;
                    end
                end
                DISCARD: begin
                    if (!utmi_rxactive) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    utmi_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en_i    (wr_en_d),
        .wr_entry_i (wr_entry_d),
        .rd_en_i    (rx_ready),
        .rd_valid_o (rx_valid),
        .rd_entry_o (head),
        .count_o    (fifo_count)
    );

    assign rx_data  = head.data;
    assign rx_sop   = head.sop;
    assign rx_eop   = head.eop;
    assign rx_err   = head.err;
    assign pkt_len  = pkt_len_q;
    assign pkt_done = pkt_done_q;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_utmi_rx_framer.sv
// tb/tb_utmi_rx_framer.sv - scoreboard bench for utmi_rx_framer
module tb_utmi_rx_framer;
    import utmi_rx_pkg::*;

    localparam int DEPTH = 16;

`ifdef UTMI_RX_PID_CHECK_EN
    localparam logic PID_ERR = 1'b1;
`else
    localparam logic PID_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxactive;
    logic        rxvalid;
    logic        rxerror;
    logic [7:0]  rxdata;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_sop;
    logic        rx_eop;
    logic        rx_err;
    logic [10:0] pkt_len;
    logic        pkt_done;
    logic [7:0]  ovf_cnt;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    rx_entry_t   exp_q[$];
    int          len_q[$];
    logic [7:0]  pkt[$];

    always #5 clk = ~clk;

    utmi_rx_framer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .utmi_rxactive (rxactive),
        .utmi_rxvalid  (rxvalid),
        .utmi_rxerror  (rxerror),
        .utmi_rxdata   (rxdata),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_sop        (rx_sop),
        .rx_eop        (rx_eop),
        .rx_err        (rx_err),
        .pkt_len       (pkt_len),
        .pkt_done      (pkt_done),
        .ovf_cnt       (ovf_cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic sop, input logic eop, input logic err, input logic [7:0] d);
        exp_q.push_back('{err: err, eop: eop, sop: sop, data: d});
    endtask

    // Pops the scoreboard on every accepted head entry and every pkt_done pulse.
    task automatic monitor();
        rx_entry_t got;
        rx_entry_t e;
        int        l;
        forever begin
            @(negedge clk);
            if (resetn && rx_valid && rx_ready) begin
                got = '{err: rx_err, eop: rx_eop, sop: rx_sop, data: rx_data};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL entry unexpected got=%h", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL entry got=%h exp=%h", got, e);
                    end
                end
            end
            if (resetn && pkt_done) begin
                done_cnt++;
                total++;
                if (len_q.size() == 0) begin
                    bad++;
                    $display("FAIL pkt_len unexpected pkt_done got=%0d", pkt_len);
                end else begin
                    l = len_q.pop_front();
                    if (int'(pkt_len) != l) begin
                        bad++;
                        $display("FAIL pkt_len got=%0d exp=%0d", pkt_len, l);
                    end
                end
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] b[$], input int err_idx);
        rxactive = 1'b1;
        rxvalid  = 1'b0;
        tick();
        for (int i = 0; i < b.size(); i++) begin
            rxvalid = 1'b1;
            rxdata  = b[i];
            rxerror = (i == err_idx);
            tick();
        end
        rxvalid  = 1'b0;
        rxerror  = 1'b0;
        rxactive = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        rxactive = 1'b0;
        rxvalid  = 1'b0;
        rxerror  = 1'b0;
        rxdata   = 8'h00;
        rx_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_fields", {rx_data, rx_sop, rx_eop, rx_err}, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_ovf", ovf_cnt, 0);
        resetn = 1'b1;
        tick();

        // Basic three-byte packet
        expect_entry(1'b1, 1'b0, 1'b0, 8'hC3);
        expect_entry(1'b0, 1'b0, 1'b0, 8'h11);
        expect_entry(1'b0, 1'b1, 1'b0, 8'h22);
        len_q.push_back(3);
        pkt = '{8'hC3, 8'h11, 8'h22};
        send_pkt(pkt, -1);
        wait_drain("drain_basic", 50);
        chk("done_basic", done_cnt, 1);

        // Receive error mid-packet lands only on the EOP entry
        expect_entry(1'b1, 1'b0, 1'b0, 8'h5A);
        expect_entry(1'b0, 1'b0, 1'b0, 8'h01);
        expect_entry(1'b0, 1'b0, 1'b0, 8'h02);
        expect_entry(1'b0, 1'b1, 1'b1, 8'h03);
        len_q.push_back(4);
        pkt = '{8'h5A, 8'h01, 8'h02, 8'h03};
        send_pkt(pkt, 1);
        wait_drain("drain_rxerr", 50);
        chk("done_rxerr", done_cnt, 2);

        // Bad PID: flagged only when the check is built in
        expect_entry(1'b1, 1'b0, 1'b0, 8'hC4);
        expect_entry(1'b0, 1'b1, PID_ERR, 8'h10);
        len_q.push_back(2);
        pkt = '{8'hC4, 8'h10};
        send_pkt(pkt, -1);
        wait_drain("drain_pid", 50);
        chk("done_pid", done_cnt, 3);

        // rxactive without any byte produces nothing
        rxactive = 1'b1;
        repeat (5) tick();
        rxactive = 1'b0;
        repeat (3) tick();
        chk("empty_done", done_cnt, 3);
        chk("empty_pkt_len", pkt_len, 2);
        chk("empty_rx_valid", rx_valid, 0);

        // Overflow: 20 bytes into a stalled 16-entry FIFO
        rx_ready = 1'b0;
        pkt.delete();
        pkt.push_back(8'hE1);
        for (int i = 1; i < 20; i++) pkt.push_back(8'(i));
        for (int i = 0; i < 15; i++) expect_entry(i == 0, 1'b0, 1'b0, pkt[i]);
        expect_entry(1'b0, 1'b1, 1'b1, 8'h13);
        len_q.push_back(20);
        send_pkt(pkt, -1);
        chk("ovf_20", ovf_cnt, 4);
        chk("len_20", pkt_len, 20);
        chk("done_20", done_cnt, 4);
        chk("valid_stalled", rx_valid, 1);

        // Full FIFO at EOP: packet pends, then later activity is discarded
        expect_entry(1'b0, 1'b1, 1'b1, 8'h77);
        len_q.push_back(2);
        pkt = '{8'h5A, 8'h77};
        send_pkt(pkt, -1);
        chk("pend_done", done_cnt, 4);
        chk("pend_ovf", ovf_cnt, 5);
        rxactive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxvalid = 1'b1;
            rxdata  = 8'hAA;
            tick();
            rxvalid = 1'b0;
            tick();
        end
        chk("pend_bytes_ovf", ovf_cnt, 8);
        rx_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            rxvalid = 1'b1;
            rxdata  = 8'hBB;
            tick();
        end
        rxvalid  = 1'b0;
        rxactive = 1'b0;
        tick();
        wait_drain("drain_pend", 100);
        repeat (2) tick();
        chk("discard_ovf", ovf_cnt, 10);
        chk("pend_done_after", done_cnt, 5);

        // Reset in the middle of a packet while the line stays active
        rx_ready = 1'b0;
        rxactive = 1'b1;
        tick();
        pkt = '{8'h5A, 8'h01, 8'h02};
        for (int i = 0; i < 3; i++) begin
            rxvalid = 1'b1;
            rxdata  = pkt[i];
            tick();
        end
        rxvalid = 1'b0;
        resetn  = 1'b0;
        tick();
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);
        chk("mid_rst_len", pkt_len, 0);
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            rxvalid = 1'b1;
            rxdata  = 8'hCC;
            tick();
        end
        rxvalid  = 1'b0;
        rxactive = 1'b0;
        tick();
        chk("mid_rst_discard_ovf", ovf_cnt, 3);
        rx_ready = 1'b1;
        repeat (3) tick();
        chk("mid_rst_no_entries", rx_valid, 0);
        chk("mid_rst_done", done_cnt, 5);

        // Recovery: normal packet after discard
        expect_entry(1'b1, 1'b0, 1'b0, 8'h5A);
        expect_entry(1'b0, 1'b1, 1'b0, 8'hBB);
        len_q.push_back(2);
        pkt = '{8'h5A, 8'hBB};
        send_pkt(pkt, -1);
        wait_drain("drain_recover", 50);
        chk("done_final", done_cnt, 6);
        chk("len_q_empty", len_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/utmi_rx_framer.md
UTMI_RX_FRAMER -- requirements
Module: utmi_rx_framer

Interface
REQ-001 Parameter DEPTH, default 16, number of FIFO entries (power of two, at least 4).
REQ-002 Port clk  input  1  UTMI-domain clock; all state changes on its rising edge.
REQ-003 Port resetn  input  1  reset, synchronous and active-low.
REQ-004 Port utmi_rxactive  input  1  PHY receive-active.
REQ-005 Port utmi_rxvalid  input  1  rxdata holds a valid byte this cycle (active-high).
REQ-006 Port utmi_rxerror  input  1  PHY receive error.
REQ-007 Port utmi_rxdata  input  8  received byte.
REQ-008 Port rx_valid  output  1  FIFO head entry valid.
REQ-009 Port rx_ready  input  1  consumer accepts the head entry when rx_valid and rx_ready are both high.
REQ-010 Port rx_data, rx_sop, rx_eop, rx_err  output  8/1/1/1  head entry fields.
REQ-011 Port pkt_len  output  11  byte count of the last completed packet.
REQ-012 Port pkt_done  output  1  one-cycle pulse when an EOP entry is written.
REQ-013 Port ovf_cnt  output  8  dropped-byte count, saturating at 255.

Function
REQ-014 The FSM SHALL have states IDLE, FIRST, RUN, PEND and DISCARD.
REQ-015 IDLE->FIRST on rxactive=1.
REQ-016 FIRST: a byte with rxvalid=1 is loaded into the hold register with sop=1, -> RUN; rxactive=0 -> IDLE with no write and no pkt_done.
REQ-017 RUN: each new rxvalid byte pushes the held byte (eop=0) and loads the new byte; rxactive=0 makes the held byte the EOP entry (eop=1).
REQ-018 A data push SHALL occur only when FIFO count <= DEPTH-2; otherwise the held byte is dropped, ovf_cnt increments and the packet err flag is set.
REQ-019 An EOP push SHALL occur when count <= DEPTH-1 -> IDLE; if the FIFO is full -> PEND, holding the entry until space is available, then write it -> IDLE.
REQ-020 PEND with rxactive=1 -> DISCARD after the EOP is written; each rxvalid byte received in PEND or DISCARD increments ovf_cnt and is not stored.
REQ-021 DISCARD -> IDLE on rxactive=0, with no entries written and no pkt_done.
REQ-022 The packet err flag is sticky from FIRST until the EOP write: it sets on rxerror=1 during rxactive, or on an overflow drop; it is carried only on the EOP entry.
REQ-023 A byte counter SHALL count every rxvalid byte of the packet, including dropped bytes, saturating at 2047; pkt_len loads it in the EOP write cycle.
REQ-024 pkt_done SHALL be high in the cycle the EOP entry is written.
REQ-025 Latency: a byte enters the FIFO in the cycle after the next rxvalid byte, or after rxactive falls; rx_valid rises the cycle after a write into an empty FIFO (no fall-through).
REQ-026 A simultaneous push and pop at count=DEPTH-2 SHALL count as a push allowed; a pop SHALL never occur when the FIFO is empty.
REQ-027 Pointers SHALL wrap modulo DEPTH; count has width log2(DEPTH)+1.

Reset
REQ-028 While resetn=0: state IDLE, FIFO empty, rx_valid=0, rx_data/sop/eop/err=0, pkt_len=0, pkt_done=0, ovf_cnt=0, hold register cleared.
REQ-029 If rxactive=1 in the first cycle after reset release, the FSM SHALL enter DISCARD.

Configuration
REQ-030 UTMI_RX_PID_CHECK_EN defined: the first byte of a packet is checked for PID[3:0]==~PID[7:4]; a mismatch sets the packet err flag.
REQ-031 UTMI_RX_PID_CHECK_EN undefined: no PID check logic is present, and err is set only as described in REQ-022.

Structure
REQ-032 Package utmi_rx_pkg SHALL hold the state enum, the FIFO entry struct {err,eop,sop,data[7:0]} and the constants LEN_W=11 and OVF_W=8.
REQ-033 Sub-module utmi_rx_fifo SHALL implement the synchronous FIFO of DEPTH entries and expose its count; the FSM, hold register and counters stay in the top level.

Verification
REQ-034 Packet C3,11,22 with rx_ready=1 -> entries {sop,C3},{11},{eop,22,err=0}; pkt_len=3; one pkt_done pulse.
REQ-035 rxerror=1 for one cycle in the middle of a 4-byte packet -> only the 4th entry has err=1; pkt_len=4.
REQ-036 rx_ready=0, DEPTH=16, 20-byte packet -> 15 data entries plus EOP entry (byte 20, err=1); ovf_cnt=4; pkt_len=20.
REQ-037 With the macro, first byte C4 -> err=1 on the EOP entry; without the macro, the same stimulus -> err=0.
REQ-038 rxactive high for 5 cycles with rxvalid=0 -> no FIFO writes, no pkt_done, pkt_len unchanged.
REQ-039 resetn low for 1 cycle in RUN with rxactive still high -> FIFO empty, rx_valid=0, DISCARD until rxactive falls, ovf_cnt counts the remaining bytes.
